// File: rtl/fifo_pixel_writer.sv
// -----------------------------------------------------------------------------
// fifo_pixel_writer
//
// Consumer stage that sits after the rasterizer's show-ahead pixel FIFO.
// It pops packed {x, y, color} entries, turns the coordinate into a linear
// framebuffer address (y*H_RES + x) and issues one write per pixel on a
// valid/ready memory port. It also counts written (and optionally clipped)
// pixels for frame bookkeeping.
//
// Optional feature macro: PIXEL_WRITER_CLIP_EN
//   defined   : out-of-range pixels (x >= H_RES or y >= V_RES) are dropped
//               in CALC and counted on o_drop_count.
//   undefined : every entry is written with the truncated address and
//               o_drop_count is tied to 0.
//
// Ports
//   clk            clock, all logic on the rising edge
//   rst_n          asynchronous active-low reset
//   i_enable       permits new pops (a pixel already in flight completes)
//   i_cnt_clr      synchronous clear of both counters (wins over increments)
//   i_fifo_data    FIFO head entry {x, y, color}, valid when not empty
//   i_fifo_empty   FIFO empty flag
//   o_fifo_rd_en   pop strobe to the FIFO
//   o_mem_addr     write address (stable while o_mem_valid is waiting)
//   o_mem_data     write data (color)
//   o_mem_valid    write request
//   i_mem_ready    memory accepts the write
//   o_busy         high whenever the FSM is not idle
//   o_pix_count    pixels written, wraps mod 2^16
//   o_drop_count   pixels clipped, wraps mod 2^16
// -----------------------------------------------------------------------------
module fifo_pixel_writer #(
    parameter int unsigned X_W     = 9,
    parameter int unsigned Y_W     = 9,
    parameter int unsigned COLOR_W = 4,
    parameter int unsigned WIDTH   = X_W + Y_W + COLOR_W,
    parameter int unsigned H_RES   = 320,
    parameter int unsigned V_RES   = 240,
    parameter int unsigned ADDR_W  = 17
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_enable,
    input  logic               i_cnt_clr,
    input  logic [WIDTH-1:0]   i_fifo_data,
    input  logic               i_fifo_empty,
    output logic               o_fifo_rd_en,
    output logic [ADDR_W-1:0]  o_mem_addr,
    output logic [COLOR_W-1:0] o_mem_data,
    output logic               o_mem_valid,
    input  logic               i_mem_ready,
    output logic               o_busy,
    output logic [15:0]        o_pix_count,
    output logic [15:0]        o_drop_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        WRITE = 2'd2
    } state_t;

`ifdef PIXEL_WRITER_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    state_t             state_q, state_d;
    logic [X_W-1:0]     x_q;
    logic [Y_W-1:0]     y_q;
    logic [COLOR_W-1:0] color_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [COLOR_W-1:0] data_q;
    logic [15:0]        pix_cnt_q, pix_cnt_d;

    logic               pop;
    logic               handshake;
    logic               out_of_range;
    logic               drop_pix;
    logic [ADDR_W-1:0]  lin_addr;

    // Head-of-FIFO field extraction: x in the MSBs, y next, color in the LSBs.
    logic [X_W-1:0]     entry_x;
    logic [Y_W-1:0]     entry_y;
    logic [COLOR_W-1:0] entry_color;

    assign entry_x     = i_fifo_data[WIDTH-1 -: X_W];
    assign entry_y     = i_fifo_data[WIDTH-1-X_W -: Y_W];
    assign entry_color = i_fifo_data[COLOR_W-1:0];

    // Pop from IDLE, or back-to-back from WRITE in the cycle the current
    // write is accepted. Gated by rst_n so no pop is requested while the
    // block is held in reset, whatever i_enable says.
    assign pop = rst_n & i_enable & ~i_fifo_empty &
                 ((state_q == IDLE) | ((state_q == WRITE) & i_mem_ready));

    assign handshake = (state_q == WRITE) & i_mem_ready;

    // Operands are truncated to ADDR_W before the multiply/add; modular
    // arithmetic makes this identical to the full-precision result's LSBs.
    assign lin_addr = ADDR_W'(y_q) * ADDR_W'(H_RES) + ADDR_W'(x_q);

    assign out_of_range = (32'(x_q) >= 32'(H_RES)) | (32'(y_q) >= 32'(V_RES));
    assign drop_pix     = CLIP_EN & (state_q == CALC) & out_of_range;

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pop) state_d = CALC;
            CALC:    state_d = drop_pix ? IDLE : WRITE;
            WRITE:   if (i_mem_ready) state_d = pop ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Pixel pipeline registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            if (pop) begin
                x_q     <= entry_x;
                y_q     <= entry_y;
                color_q <= entry_color;
            end
            // addr/data only move in CALC, so they stay frozen while WRITE
            // waits on backpressure even if the next entry has been popped.
            if (state_q == CALC) begin
                addr_q <= lin_addr;
                data_q <= color_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Counters (clear has priority over increment)
    // ------------------------------------------------------------------
    always_comb begin
        pix_cnt_d = pix_cnt_q;
        if (i_cnt_clr) begin
            pix_cnt_d = '0;
        end else if (handshake) begin
            pix_cnt_d = pix_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt_q <= '0;
        end else begin
            pix_cnt_q <= pix_cnt_d;
        end
    end

`ifdef PIXEL_WRITER_CLIP_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (i_cnt_clr) begin
            drop_cnt_d = '0;
        end else if (drop_pix) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_drop_count = drop_cnt_q;
`else
    assign o_drop_count = '0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_fifo_rd_en = pop;
    assign o_mem_valid  = (state_q == WRITE);
    assign o_mem_addr   = addr_q;
    assign o_mem_data   = data_q;
    assign o_busy       = (state_q != IDLE);
    assign o_pix_count  = pix_cnt_q;

endmodule

// File: tb/tb_fifo_pixel_writer.sv
// -----------------------------------------------------------------------------
// tb_fifo_pixel_writer
//
// Directed testbench for fifo_pixel_writer. A queue models the show-ahead
// FIFO; every write handshake is logged and printed on one line. Each task
// covers one scenario with hand-computed expected values.
// Build with or without PIXEL_WRITER_CLIP_EN to match the RTL.
// -----------------------------------------------------------------------------
module tb_fifo_pixel_writer;

    localparam int X_W     = 9;
    localparam int Y_W     = 9;
    localparam int COLOR_W = 4;
    localparam int WIDTH   = X_W + Y_W + COLOR_W;
    localparam int ADDR_W  = 17;

`ifdef PIXEL_WRITER_CLIP_EN
    localparam int CLIP_EXP_PIX  = 8;
    localparam int CLIP_EXP_DROP = 1;
    localparam int CLIP_EXP_WR   = 1;
`else
    localparam int CLIP_EXP_PIX  = 9;
    localparam int CLIP_EXP_DROP = 0;
    localparam int CLIP_EXP_WR   = 2;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               i_enable;
    logic               i_cnt_clr;
    logic [WIDTH-1:0]   i_fifo_data;
    logic               i_fifo_empty;
    logic               o_fifo_rd_en;
    logic [ADDR_W-1:0]  o_mem_addr;
    logic [COLOR_W-1:0] o_mem_data;
    logic               o_mem_valid;
    logic               i_mem_ready;
    logic               o_busy;
    logic [15:0]        o_pix_count;
    logic [15:0]        o_drop_count;

    always #5 clk = ~clk;

    fifo_pixel_writer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_enable     (i_enable),
        .i_cnt_clr    (i_cnt_clr),
        .i_fifo_data  (i_fifo_data),
        .i_fifo_empty (i_fifo_empty),
        .o_fifo_rd_en (o_fifo_rd_en),
        .o_mem_addr   (o_mem_addr),
        .o_mem_data   (o_mem_data),
        .o_mem_valid  (o_mem_valid),
        .i_mem_ready  (i_mem_ready),
        .o_busy       (o_busy),
        .o_pix_count  (o_pix_count),
        .o_drop_count (o_drop_count)
    );

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;

    logic [WIDTH-1:0]   fifo_q[$];
    logic [ADDR_W-1:0]  wr_addr[$];
    logic [COLOR_W-1:0] wr_data[$];
    int                 pop_cyc[$];

    function automatic logic [WIDTH-1:0] pack(input int x, input int y, input int c);
        return {X_W'(x), Y_W'(y), COLOR_W'(c)};
    endfunction

    task automatic sync_fifo();
        i_fifo_empty = (fifo_q.size() == 0);
        i_fifo_data  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    endtask

    task automatic push(input int x, input int y, input int c);
        fifo_q.push_back(pack(x, y, c));
        sync_fifo();
    endtask

    // One clock: sample pop/handshake ahead of the edge, apply the pop
    // afterwards, then let combinational outputs settle.
    task automatic step();
        logic popped;
        logic hs;
        #1;
        popped = o_fifo_rd_en;
        hs     = o_mem_valid & i_mem_ready & rst_n;
        if (hs) begin
            wr_addr.push_back(o_mem_addr);
            wr_data.push_back(o_mem_data);
            $display("[TB] write addr=%0d data=0x%0h", o_mem_addr, o_mem_data);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (popped) begin
            pop_cyc.push_back(cyc);
            ntests++;
            if (fifo_q.size() == 0) begin
                nfail++;
                $display("FAIL pop_while_empty: rd_en=1 got empty=1 want empty=0");
            end else begin
                void'(fifo_q.pop_front());
            end
        end
        sync_fifo();
        #1;
    endtask

    task automatic clear_logs();
        wr_addr.delete();
        wr_data.delete();
        pop_cyc.delete();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0; i_enable = 1'b1; i_cnt_clr = 1'b0; i_mem_ready = 1'b1;
        sync_fifo();
        #2;
        ntests++; if (o_mem_valid !== 1'b0) begin nfail++; $display("FAIL rst_valid: got %0b want 0", o_mem_valid); end
        ntests++; if (o_busy !== 1'b0) begin nfail++; $display("FAIL rst_busy: got %0b want 0", o_busy); end
        ntests++; if (o_mem_addr !== '0) begin nfail++; $display("FAIL rst_addr: got %0d want 0", o_mem_addr); end
        ntests++; if (o_pix_count !== 16'd0) begin nfail++; $display("FAIL rst_pix: got %0d want 0", o_pix_count); end
        push(1, 1, 1);
        #1;
        ntests++; if (o_fifo_rd_en !== 1'b0) begin nfail++; $display("FAIL rst_rd_en_gated: got %0b want 0", o_fifo_rd_en); end
        fifo_q.delete(); sync_fifo();
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        ntests++; if (o_fifo_rd_en !== 1'b0) begin nfail++; $display("FAIL rst_rel_rd_en: got %0b want 0", o_fifo_rd_en); end
        ntests++; if (o_busy !== 1'b0) begin nfail++; $display("FAIL rst_rel_busy: got %0b want 0", o_busy); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_single();
        clear_logs();
        i_mem_ready = 1'b1;
        push(5, 2, 4'hA);
        #1;
        ntests++; if (o_fifo_rd_en !== 1'b1) begin nfail++; $display("FAIL single_pop: got %0b want 1", o_fifo_rd_en); end
        step();
        ntests++; if (o_fifo_rd_en !== 1'b0) begin nfail++; $display("FAIL single_pop_once: got %0b want 0", o_fifo_rd_en); end
        ntests++; if (o_mem_valid !== 1'b0) begin nfail++; $display("FAIL single_valid_early: got %0b want 0", o_mem_valid); end
        ntests++; if (o_busy !== 1'b1) begin nfail++; $display("FAIL single_busy: got %0b want 1", o_busy); end
        step();
        ntests++; if (o_mem_valid !== 1'b1) begin nfail++; $display("FAIL single_valid: got %0b want 1", o_mem_valid); end
        ntests++; if (o_mem_addr !== 17'd645) begin nfail++; $display("FAIL single_addr: got %0d want 645", o_mem_addr); end
        ntests++; if (o_mem_data !== 4'hA) begin nfail++; $display("FAIL single_data: got 0x%0h want 0xa", o_mem_data); end
        step();
        ntests++; if (o_pix_count !== 16'd1) begin nfail++; $display("FAIL single_count: got %0d want 1", o_pix_count); end
        ntests++; if (o_busy !== 1'b0) begin nfail++; $display("FAIL single_idle: got %0b want 0", o_busy); end
        ntests++; if (o_mem_valid !== 1'b0) begin nfail++; $display("FAIL single_valid_drop: got %0b want 0", o_mem_valid); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_backpressure();
        clear_logs();
        i_mem_ready = 1'b0;
        push(10, 1, 3);   // addr 330
        push(1, 0, 5);    // addr 1
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            ntests++; if (o_mem_valid !== 1'b1) begin nfail++; $display("FAIL bp_valid[%0d]: got %0b want 1", i, o_mem_valid); end
            ntests++; if (o_mem_addr !== 17'd330) begin nfail++; $display("FAIL bp_addr[%0d]: got %0d want 330", i, o_mem_addr); end
            ntests++; if (o_mem_data !== 4'h3) begin nfail++; $display("FAIL bp_data[%0d]: got 0x%0h want 0x3", i, o_mem_data); end
            ntests++; if (o_fifo_rd_en !== 1'b0) begin nfail++; $display("FAIL bp_no_pop[%0d]: got %0b want 0", i, o_fifo_rd_en); end
            step();
        end
        i_mem_ready = 1'b1;
        #1;
        ntests++; if (o_fifo_rd_en !== 1'b1) begin nfail++; $display("FAIL bp_pop_on_ready: got %0b want 1", o_fifo_rd_en); end
        step();
        ntests++; if (o_pix_count !== 16'd2) begin nfail++; $display("FAIL bp_count: got %0d want 2", o_pix_count); end
        ntests++; if (o_mem_valid !== 1'b0) begin nfail++; $display("FAIL bp_calc_valid: got %0b want 0", o_mem_valid); end
        step();
        ntests++; if (o_mem_addr !== 17'd1) begin nfail++; $display("FAIL bp_addr2: got %0d want 1", o_mem_addr); end
        step();
        ntests++; if (o_pix_count !== 16'd3) begin nfail++; $display("FAIL bp_count2: got %0d want 3", o_pix_count); end
        ntests++; if (wr_addr.size() !== 2) begin nfail++; $display("FAIL bp_writes: got %0d want 2", wr_addr.size()); end
        ntests++; if (wr_addr[0] !== 17'd330) begin nfail++; $display("FAIL bp_wr0: got %0d want 330", wr_addr[0]); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_streaming();
        logic [ADDR_W-1:0]  exp_addr[4];
        logic [COLOR_W-1:0] exp_data[4];
        int n;
        exp_addr = '{17'd0, 17'd76799, 17'd967, 17'd32100};
        exp_data = '{4'h1, 4'hF, 4'h2, 4'h6};
        clear_logs();
        i_mem_ready = 1'b1;
        push(0, 0, 1);
        push(319, 239, 15);
        push(7, 3, 2);
        push(100, 100, 6);
        n = 0;
        while (!(wr_addr.size() == 4 && !o_busy) && n < 30) begin
            step();
            n++;
        end
        ntests++; if (n >= 30) begin nfail++; $display("FAIL stream_timeout: got %0d cycles want <30", n); end
        ntests++; if (pop_cyc.size() !== 4) begin nfail++; $display("FAIL stream_pops: got %0d want 4", pop_cyc.size()); end
        for (int i = 1; i < 4; i++) begin
            ntests++;
            if (pop_cyc[i] - pop_cyc[i-1] !== 2) begin
                nfail++; $display("FAIL stream_pop_gap[%0d]: got %0d want 2", i, pop_cyc[i] - pop_cyc[i-1]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            ntests++;
            if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
                nfail++; $display("FAIL stream_wr[%0d]: got %0d/0x%0h want %0d/0x%0h", i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
            end
        end
        ntests++; if (o_pix_count !== 16'd7) begin nfail++; $display("FAIL stream_count: got %0d want 7", o_pix_count); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_clip();
        int n;
        clear_logs();
        i_mem_ready = 1'b1;
        push(320, 0, 9);
        push(2, 0, 4);
        n = 0;
        while (!(pop_cyc.size() == 2 && !o_busy) && n < 20) begin
            step();
            n++;
        end
        ntests++; if (n >= 20) begin nfail++; $display("FAIL clip_timeout: got %0d cycles want <20", n); end
        ntests++;
        if (pop_cyc.size() !== 2 || pop_cyc[1] - pop_cyc[0] !== 2) begin
            nfail++; $display("FAIL clip_pop_gap: got %0d pops gap %0d want 2 pops gap 2", pop_cyc.size(), pop_cyc[1] - pop_cyc[0]);
        end
        ntests++; if (wr_addr.size() !== CLIP_EXP_WR) begin nfail++; $display("FAIL clip_writes: got %0d want %0d", wr_addr.size(), CLIP_EXP_WR); end
`ifdef PIXEL_WRITER_CLIP_EN
        ntests++; if (wr_addr[0] !== 17'd2) begin nfail++; $display("FAIL clip_wr0: got %0d want 2", wr_addr[0]); end
`else
        ntests++; if (wr_addr[0] !== 17'd320 || wr_data[0] !== 4'h9) begin nfail++; $display("FAIL clip_wr0: got %0d/0x%0h want 320/0x9", wr_addr[0], wr_data[0]); end
        ntests++; if (wr_addr[1] !== 17'd2) begin nfail++; $display("FAIL clip_wr1: got %0d want 2", wr_addr[1]); end
`endif
        ntests++; if (o_drop_count !== 16'(CLIP_EXP_DROP)) begin nfail++; $display("FAIL clip_drop: got %0d want %0d", o_drop_count, CLIP_EXP_DROP); end
        ntests++; if (o_pix_count !== 16'(CLIP_EXP_PIX)) begin nfail++; $display("FAIL clip_pix: got %0d want %0d", o_pix_count, CLIP_EXP_PIX); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_cnt_clr();
        clear_logs();
        i_mem_ready = 1'b1;
        push(1, 1, 1);
        step();
        step();
        ntests++; if (o_mem_valid !== 1'b1) begin nfail++; $display("FAIL clr_valid: got %0b want 1", o_mem_valid); end
        i_cnt_clr = 1'b1;
        step();
        i_cnt_clr = 1'b0;
        ntests++; if (o_pix_count !== 16'd0) begin nfail++; $display("FAIL clr_pix: got %0d want 0", o_pix_count); end
        ntests++; if (o_drop_count !== 16'd0) begin nfail++; $display("FAIL clr_drop: got %0d want 0", o_drop_count); end
        ntests++; if (wr_addr.size() !== 1 || wr_addr[0] !== 17'd321) begin nfail++; $display("FAIL clr_write: got %0d writes addr %0d want 1 addr 321", wr_addr.size(), wr_addr[0]); end
        step();
        ntests++; if (o_pix_count !== 16'd0) begin nfail++; $display("FAIL clr_hold: got %0d want 0", o_pix_count); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_enable();
        clear_logs();
        i_mem_ready = 1'b1;
        push(4, 0, 7);
        push(5, 0, 8);
        step();                 // first entry popped, now in CALC
        i_enable = 1'b0;
        #1;
        ntests++; if (o_fifo_rd_en !== 1'b0) begin nfail++; $display("FAIL en_no_pop: got %0b want 0", o_fifo_rd_en); end
        step();
        ntests++; if (o_mem_valid !== 1'b1 || o_mem_addr !== 17'd4) begin nfail++; $display("FAIL en_write: got valid %0b addr %0d want 1/4", o_mem_valid, o_mem_addr); end
        step();
        ntests++; if (o_busy !== 1'b0) begin nfail++; $display("FAIL en_idle: got %0b want 0", o_busy); end
        ntests++; if (o_pix_count !== 16'd1) begin nfail++; $display("FAIL en_count: got %0d want 1", o_pix_count); end
        for (int i = 0; i < 3; i++) step();
        ntests++; if (pop_cyc.size() !== 1) begin nfail++; $display("FAIL en_pops: got %0d want 1", pop_cyc.size()); end
        ntests++; if (fifo_q.size() !== 1) begin nfail++; $display("FAIL en_fifo_left: got %0d want 1", fifo_q.size()); end
        i_enable = 1'b1;
        step(); step(); step();
        ntests++; if (o_pix_count !== 16'd2) begin nfail++; $display("FAIL en_resume: got %0d want 2", o_pix_count); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_midstream();
        clear_logs();
        i_mem_ready = 1'b0;
        push(9, 9, 5);          // addr 2889
        push(3, 3, 3);
        step();
        step();
        ntests++; if (o_mem_valid !== 1'b1 || o_mem_addr !== 17'd2889) begin nfail++; $display("FAIL mrst_pre: got valid %0b addr %0d want 1/2889", o_mem_valid, o_mem_addr); end
        rst_n = 1'b0;
        #1;
        ntests++; if (o_mem_valid !== 1'b0) begin nfail++; $display("FAIL mrst_valid: got %0b want 0", o_mem_valid); end
        ntests++; if (o_busy !== 1'b0) begin nfail++; $display("FAIL mrst_busy: got %0b want 0", o_busy); end
        ntests++; if (o_fifo_rd_en !== 1'b0) begin nfail++; $display("FAIL mrst_rd_en: got %0b want 0", o_fifo_rd_en); end
        ntests++; if (o_mem_addr !== '0 || o_mem_data !== '0) begin nfail++; $display("FAIL mrst_addr_data: got %0d/0x%0h want 0/0x0", o_mem_addr, o_mem_data); end
        ntests++; if (o_pix_count !== 16'd0 || o_drop_count !== 16'd0) begin nfail++; $display("FAIL mrst_counts: got %0d/%0d want 0/0", o_pix_count, o_drop_count); end
        fifo_q.delete(); sync_fifo();
        i_mem_ready = 1'b1;
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step();
        ntests++; if (o_fifo_rd_en !== 1'b0 || o_busy !== 1'b0) begin nfail++; $display("FAIL mrst_after: got rd_en %0b busy %0b want 0/0", o_fifo_rd_en, o_busy); end
        ntests++; if (wr_addr.size() !== 0) begin nfail++; $display("FAIL mrst_lost: got %0d writes want 0", wr_addr.size()); end
        ntests++; if (o_pix_count !== 16'd0) begin nfail++; $display("FAIL mrst_pix_after: got %0d want 0", o_pix_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_streaming();
        test_clip();
        test_cnt_clr();
        test_enable();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
